mod_counter_ctrl: RTL and testbench
===================================

Name: mod_counter_ctrl

Overview:
Run controller for a modulo-N counter. On command, it runs the counter for a programmed number of full modulo periods and reports a pulse on each wrap. It supports pause, abort, and a start/busy/done handshake. It sits between a host sequencer and the counter datapath, so the counter only advances under controller supervision.

Parameters:
MOD, 5, counter modulus; Q counts 0..MOD-1 (MOD >= 2)
WIDTH, 3, width of Q; must satisfy 2**WIDTH >= MOD
CNT_W, 8, width of the period-count command and the remaining-count status

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a run; sampled only in IDLE
num_cycles  input  CNT_W  number of full MOD periods to run; latched on accepted start
pause  input  1  level; hold the counter while high
abort  input  1  level; terminate the run immediately, with no done
Q  output  WIDTH  current count value
wrap  output  1  one-cycle pulse, high in the cycle Q returns to 0 from MOD-1
busy  output  1  high in RUN and PAUSE
paused  output  1  high in PAUSE
done  output  1  one-cycle pulse on normal completion
cycles_left  output  CNT_W  periods remaining, including the current period

Behaviour:
- All outputs are registered. reset=0 forces, asynchronously: state=IDLE, Q=0, wrap=0, busy=0, paused=0, done=0, cycles_left=0. This applies mid-run as well.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - start=1 and num_cycles!=0: latch cycles_left=num_cycles, go to RUN, Q stays 0 on this edge.
  - start=1 and num_cycles==0: go to DONE directly, with no counting.
  - Otherwise Q holds at 0.
- RUN, evaluated in priority order at each edge:
  1. abort: go to IDLE, Q=0, cycles_left=0, no done.
  2. pause: go to PAUSE, Q holds.
  3. Otherwise Q increments.
     - If Q==MOD-1: Q=0, wrap=1, cycles_left decrements.
     - If cycles_left was 1 at that edge: go to DONE instead of staying in RUN.
- PAUSE:
  - abort: go to IDLE, as in RUN.
  - pause=1: Q holds.
  - pause=0: increment on this same edge (same wrap/completion rules as RUN) and return to RUN.
  - Net effect: Q is frozen for exactly the number of edges on which pause was sampled high.
- DONE: done=1 for exactly one cycle, busy=0. Go to IDLE at the next edge; start is ignored in DONE.
- start is ignored while busy=1. num_cycles is only sampled on an accepted start.
- Simultaneous events:
  - abort has priority over pause, wrap and completion. A final wrap coinciding with abort gives IDLE and no done.
  - start together with abort in IDLE: abort wins, stay in IDLE.
- Latency and duration:
  - Accepted start at edge k gives busy=1 from edge k.
  - First Q=1 at edge k+1.
  - With no pauses, done=1 at edge k + num_cycles*MOD, coincident with the final wrap and Q=0.
- Width rules:
  - cycles_left never underflows.
  - Q never takes values >= MOD.
  - num_cycles = 2**CNT_W-1 is legal.

Decomposition:
- Shared package mod_ctrl_pkg:
  - state encoding localparams: S_IDLE=2'b00, S_RUN=2'b01, S_PAUSE=2'b10, S_DONE=2'b11
  - helper constant for MOD-1
- Natural sub-module: mod_n_counter.
  - Parameters: MOD, WIDTH.
  - Inputs: clk, reset (async active-low), en, clr.
  - Outputs: Q, wrap_next (combinational: en && Q==MOD-1).
- The FSM and cycles_left register stay in mod_counter_ctrl.

Test Plan:
- Reset with start=1 and num_cycles=3 held -> all outputs 0 and state IDLE. Release reset, then start=1 with num_cycles=2 for one cycle -> Q sequence 0,1,2,3,4,0,1,2,3,4,0; wrap high at both returns to 0; cycles_left 2 then 1 then 0; busy high for 10 cycles; done high for one cycle at the second wrap, then IDLE.
- Run with num_cycles=1; hold pause high for 3 edges when Q=2 -> Q stays 2 for 3 extra cycles with paused=1; then Q=3,4,0; done at edge 8 after start.
- Run with num_cycles=3; assert abort when Q=3 with cycles_left=2 -> next edge Q=0, busy=0, cycles_left=0, done never asserted.
- start=1 with num_cycles=0 -> done pulse one cycle later; Q stays 0; busy and wrap stay 0.
- During a run, pulse start with num_cycles=7 -> ignored; cycles_left and sequence unchanged. Drop reset asynchronously (mid-clock) while Q=4 -> Q=0, busy=0 immediately, before the next edge.
- On the final wrap edge, assert abort and pause together -> IDLE, Q=0, no done, no wrap.

Source files
------------

// File: rtl/mod_ctrl_pkg.sv
// Shared types and helpers for the modulo-N run controller and its counter.
package mod_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam int unsigned MOD_DEFAULT      = 5;
  localparam int unsigned MOD_LAST_DEFAULT = MOD_DEFAULT - 1;

  // Terminal count of a modulo-mod counter.
  function automatic int unsigned mod_last(input int unsigned mod);
    return mod - 1;
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up-counter with enable and synchronous clear; flags the coming wrap.
module mod_n_counter
  import mod_ctrl_pkg::*;
#(
  parameter int MOD   = 5,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] Q,
  output logic             wrap_next
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(mod_last(MOD));

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= (r_q == LAST) ? '0 : r_q + 1'b1;
    end
  end

  assign Q         = r_q;
  assign wrap_next = en && (r_q == LAST);

endmodule

// File: rtl/mod_counter_ctrl.sv
// Run controller: runs a modulo-N counter for a commanded number of periods,
// with pause, abort and a start/busy/done handshake.
module mod_counter_ctrl
  import mod_ctrl_pkg::*;
#(
  parameter int MOD   = 5,
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] Q,
  output logic             wrap,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic [CNT_W-1:0] cycles_left
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cycles_left;
  logic             r_wrap;
  logic             r_busy;
  logic             r_paused;
  logic             r_done;

  logic w_active;
  logic w_en;
  logic w_clr;
  logic w_wrap_next;

  assign w_active = (r_state == S_RUN) || (r_state == S_PAUSE);
  // Abort and pause both suppress the increment, so no wrap can fire with them.
  assign w_en     = w_active && !abort && !pause;
  assign w_clr    = w_active && abort;

  mod_n_counter #(
    .MOD   (MOD),
    .WIDTH (WIDTH)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .en        (w_en),
    .clr       (w_clr),
    .Q         (Q),
    .wrap_next (w_wrap_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cycles_left <= '0;
      r_wrap        <= 1'b0;
      r_busy        <= 1'b0;
      r_paused      <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            if (num_cycles != '0) begin
              r_state       <= S_RUN;
              r_cycles_left <= num_cycles;
              r_busy        <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN, S_PAUSE: begin
          if (abort) begin
            r_state       <= S_IDLE;
            r_cycles_left <= '0;
            r_busy        <= 1'b0;
            r_paused      <= 1'b0;
          end else if (pause) begin
            r_state  <= S_PAUSE;
            r_paused <= 1'b1;
          end else begin
            r_paused <= 1'b0;
            r_state  <= S_RUN;
            if (w_wrap_next) begin
              r_wrap <= 1'b1;
              if (r_cycles_left != '0) begin
                r_cycles_left <= r_cycles_left - 1'b1;
              end
              if (r_cycles_left == CNT_W'(1)) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wrap        = r_wrap;
  assign busy        = r_busy;
  assign paused      = r_paused;
  assign done        = r_done;
  assign cycles_left = r_cycles_left;

endmodule

// File: tb/tb_mod_counter_ctrl.sv
// Scoreboard bench for mod_counter_ctrl: a cycle model pushes expected outputs,
// which are popped and compared after each clock edge.
module tb_mod_counter_ctrl;

  localparam int MOD   = 5;
  localparam int WIDTH = 3;
  localparam int CNT_W = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] num_cycles;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] Q;
  logic             wrap;
  logic             busy;
  logic             paused;
  logic             done;
  logic [CNT_W-1:0] cycles_left;

  mod_counter_ctrl #(
    .MOD   (MOD),
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_cycles  (num_cycles),
    .pause       (pause),
    .abort       (abort),
    .Q           (Q),
    .wrap        (wrap),
    .busy        (busy),
    .paused      (paused),
    .done        (done),
    .cycles_left (cycles_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int q;
    int wrap;
    int busy;
    int paused;
    int done;
    int left;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0=idle 1=run 2=pause 3=done
  int m_state = 0;
  int m_q     = 0;
  int m_left  = 0;
  int m_wrap  = 0;

  // Statistics gathered from DUT outputs, relative to the last clear_stats.
  int edge_no;
  int done_at;
  int done_cnt;
  int busy_cnt;
  int wrap_cnt;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_q     = 0;
    m_left  = 0;
    m_wrap  = 0;
  endtask

  task automatic model_edge(input bit s, input int n, input bit p, input bit a);
    m_wrap = 0;
    if (!reset) begin
      model_reset();
      return;
    end
    case (m_state)
      0: begin
        if (!a && s) begin
          if (n != 0) begin
            m_state = 1;
            m_left  = n;
          end else begin
            m_state = 3;
          end
        end
      end
      1, 2: begin
        if (a) begin
          m_state = 0;
          m_q     = 0;
          m_left  = 0;
        end else if (p) begin
          m_state = 2;
        end else begin
          m_state = 1;
          if (m_q == MOD - 1) begin
            m_q    = 0;
            m_wrap = 1;
            if (m_left == 1) m_state = 3;
            if (m_left > 0) m_left = m_left - 1;
          end else begin
            m_q = m_q + 1;
          end
        end
      end
      default: m_state = 0;
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.q      = m_q;
    e.wrap   = m_wrap;
    e.busy   = (m_state == 1 || m_state == 2) ? 1 : 0;
    e.paused = (m_state == 2) ? 1 : 0;
    e.done   = (m_state == 3) ? 1 : 0;
    e.left   = m_left;
    return e;
  endfunction

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb_q.pop_front();
    $display("t=%0t %s Q=%0d wrap=%0b busy=%0b paused=%0b done=%0b left=%0d",
             $time, tag, Q, wrap, busy, paused, done, cycles_left);
    check_val({tag, "_Q"}, int'(Q), e.q);
    check_val({tag, "_wrap"}, int'(wrap), e.wrap);
    check_val({tag, "_busy"}, int'(busy), e.busy);
    check_val({tag, "_paused"}, int'(paused), e.paused);
    check_val({tag, "_done"}, int'(done), e.done);
    check_val({tag, "_left"}, int'(cycles_left), e.left);
  endtask

  task automatic clear_stats();
    edge_no  = -1;
    done_at  = -1;
    done_cnt = 0;
    busy_cnt = 0;
    wrap_cnt = 0;
  endtask

  // Drive inputs away from the edge, predict, wait one edge, compare.
  task automatic step(input string tag, input bit s, input int n, input bit p, input bit a);
    start      = s;
    num_cycles = CNT_W'(n);
    pause      = p;
    abort      = a;
    model_edge(s, n, p, a);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    compare_pop(tag);
    edge_no++;
    if (done) begin
      done_cnt++;
      if (done_at < 0) done_at = edge_no;
    end
    if (busy) busy_cnt++;
    if (wrap) wrap_cnt++;
  endtask

  task automatic run_until(input string tag, input int tq, input int tl, input int maxn);
    int k;
    k = 0;
    while (!(m_q == tq && (tl < 0 || m_left == tl)) && k < maxn) begin
      step(tag, 0, 0, 0, 0);
      k++;
    end
    if (k >= maxn) check_val({tag, "_timeout"}, 1, 0);
  endtask

  task automatic run_until_idle(input string tag, input int maxn);
    int k;
    k = 0;
    while (m_state != 0 && k < maxn) begin
      step(tag, 0, 0, 0, 0);
      k++;
    end
    if (k >= maxn) check_val({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b1;
    num_cycles = CNT_W'(3);
    pause      = 1'b0;
    abort      = 1'b0;
    model_reset();

    // Reset held with a start pending: everything stays cleared.
    repeat (3) step("rst_hold", 1, 3, 0, 0);
    reset = 1'b1;
    step("idle", 0, 0, 0, 0);

    // Two full periods.
    clear_stats();
    step("run2_start", 1, 2, 0, 0);
    run_until_idle("run2", 20);
    check_val("run2_done_edge", done_at, 2 * MOD);
    check_val("run2_busy_cycles", busy_cnt, 2 * MOD);
    check_val("run2_wraps", wrap_cnt, 2);
    check_val("run2_done_pulses", done_cnt, 1);

    // One period with a three-edge pause at Q=2.
    clear_stats();
    step("pause_start", 1, 1, 0, 0);
    run_until("pause_run", 2, -1, 10);
    repeat (3) step("pause_hold", 0, 0, 1, 0);
    run_until_idle("pause_tail", 20);
    check_val("pause_done_edge", done_at, 8);

    // Abort mid-run.
    clear_stats();
    step("abort_start", 1, 3, 0, 0);
    run_until("abort_run", 3, 2, 20);
    step("abort_hit", 0, 0, 0, 1);
    check_val("abort_Q_after", int'(Q), 0);
    repeat (3) step("abort_idle", 0, 0, 0, 0);
    check_val("abort_done_pulses", done_cnt, 0);

    // Zero-length run.
    clear_stats();
    step("zero_start", 1, 0, 0, 0);
    step("zero_after", 0, 0, 0, 0);
    check_val("zero_done_pulses", done_cnt, 1);
    check_val("zero_busy_cycles", busy_cnt, 0);
    check_val("zero_wraps", wrap_cnt, 0);

    // Start with abort in IDLE: abort wins.
    step("start_abort", 1, 4, 0, 1);

    // Start ignored while busy, then asynchronous reset mid-cycle at Q=4.
    step("ign_start", 1, 2, 0, 0);
    step("ign_run", 0, 0, 0, 0);
    step("ign_pulse", 1, 7, 0, 0);
    run_until("ign_run2", 4, -1, 10);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    sb_q.push_back(model_out());
    compare_pop("async_rst");
    @(negedge clk);
    reset = 1'b1;
    step("post_rst", 0, 0, 0, 0);

    // Final wrap with abort and pause together.
    clear_stats();
    step("fin_start", 1, 1, 0, 0);
    run_until("fin_run", 4, -1, 10);
    step("fin_abort", 0, 0, 1, 1);
    repeat (2) step("fin_idle", 0, 0, 0, 0);
    check_val("fin_done_pulses", done_cnt, 0);
    check_val("fin_wraps", wrap_cnt, 0);

    // Largest legal period count is latched intact.
    step("max_start", 1, (1 << CNT_W) - 1, 0, 0);
    repeat (3) step("max_run", 0, 0, 0, 0);
    step("max_abort", 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
